// File: rtl/display_tx.sv
// display_tx: serial byte transmitter for a display link, with optional even parity and a frame counter
module display_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       sig,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_cnt
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t r_state, w_next;
   logic [7:0] r_cnt, r_shift, r_frames;
   logic [2:0] r_idx, w_idx_nxt;
   logic r_sig, w_tick, w_sig_nxt;
   assign w_tick = r_cnt == 8'(CLKS_PER_BIT - 1);
   assign w_idx_nxt = r_state != DATA ? 3'd0 : w_tick ? r_idx + 3'd1 : r_idx;
   assign sig = r_sig;
   assign frame_cnt = r_frames;
   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next = START;
         START:   if (w_tick) w_next = DATA;
         DATA:    if (w_tick && r_idx == 3'd7) w_next = PARITY_EN ? PARITY : STOP;
         PARITY:  if (w_tick) w_next = STOP;
         STOP:    if (w_tick) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // sig is registered from the upcoming state so each bit appears exactly on its boundary edge
   always_comb begin
      in_ready  = r_state == IDLE;
      busy      = r_state != IDLE;
      done      = r_state == STOP && w_tick;
      w_sig_nxt = w_next == START  ? 1'b0 :
                  w_next == DATA   ? r_shift[w_idx_nxt] :
                  w_next == PARITY ? ^r_shift : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_sig    <= 1'b1;
         r_frames <= '0;
      end else begin
         r_cnt <= (r_state == IDLE || w_tick) ? 8'd0 : r_cnt + 8'd1;
         r_idx <= w_idx_nxt;
         r_sig <= w_sig_nxt;
         if (in_valid && in_ready) r_shift <= in_data;
         if (done) r_frames <= r_frames + 8'd1;
      end
   end
endmodule

// File: tb/tb_display_tx.sv
// tb_display_tx: scoreboarded waveform checks for display_tx, plus no-parity, back-to-back, abort and wrap sequences
module tb_display_tx;
   logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, v1 = 1'b0;
   logic [7:0] in_data = '0, d1 = '0;
   logic in_ready, sig, busy, done, rdy1, sig1, busy1, done1;
   logic [7:0] frame_cnt, fc1;
   int ntests = 0, nfail = 0, ndone = 0, cyc = 0, n = 0;
   bit col = 1'b0;
   logic [43:0] vec, e;
   logic [43:0] exp_q[$];
   int starts[$];

   display_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sig(sig), .busy(busy), .done(done), .frame_cnt(frame_cnt));
   display_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_np (
      .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
      .sig(sig1), .busy(busy1), .done(done1), .frame_cnt(fc1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [43:0] wave(input logic [7:0] d, input logic p);
      logic [43:0] w = '0;
      logic b;
      for (int s = 0; s < 11; s++) begin
         b = s == 0 ? 1'b0 : s <= 8 ? d[s-1] : s == 9 ? p : 1'b1;
         for (int c = 0; c < 4; c++) w[s*4+c] = b;
      end
      return w;
   endfunction

   // frame monitor: captures sig each cycle from the start bit until done and scores it
   always @(negedge clk) begin
      cyc++;
      if (!reset) col = 1'b0;
      else begin
         if (!col && sig === 1'b0) begin
            col = 1'b1; n = 0; vec = '0;
            starts.push_back(cyc);
         end
         if (col) begin
            vec[n] = sig;
            n++;
            if (done) begin
               ndone++;
               col = 1'b0;
               if (exp_q.size() == 0) check("unexpected_frame", 64'(exp_q.size()), 64'd1);
               else begin
                  e = exp_q.pop_front();
                  check("frame_wave", 64'(vec), 64'(e));
                  check("frame_len", 64'(n), 64'd44);
               end
            end else if (n >= 44) begin
               check("done_timeout", 64'(done), 64'd1);
               col = 1'b0;
            end
         end else if (done) check("stray_done", 64'(done), 64'd0);
      end
   end

   task automatic send(input logic [7:0] d, input logic p);
      int k = 0;
      do begin @(negedge clk); k++; end while (!in_ready && k < 100);
      check("ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data = d;
      exp_q.push_back(wave(d, p));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (ndone < target && k < 200) begin @(negedge clk); #1; k++; end
      check("wait_done", 64'(ndone >= target), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
   endtask

   typedef struct {logic [7:0] d; logic p; logic [7:0] cnt;} vec_t;
   vec_t tbl[6];
   int base, k;
   logic [7:0] rd;
   logic [39:0] v40;
   int dpos;

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 8'd1};
      tbl[1] = '{8'h07, 1'b1, 8'd2};
      tbl[2] = '{8'h00, 1'b0, 8'd3};
      tbl[3] = '{8'h80, 1'b1, 8'd4};
      tbl[4] = '{8'h3C, 1'b0, 8'd5};
      tbl[5] = '{8'hFE, 1'b1, 8'd6};
      in_valid = 1'b1;
      in_data = 8'h5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sig", 64'(sig), 64'd1);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("no_hs_in_reset", 64'({sig, busy}), 64'b10);

      for (int i = 0; i < 6; i++) begin
         base = ndone;
         send(tbl[i].d, tbl[i].p);
         if (i == 0) begin
            @(negedge clk);
            check("busy_mid", 64'({busy, in_ready}), 64'b10);
         end
         wait_done(base + 1);
         @(negedge clk);
         check("frame_cnt", 64'(frame_cnt), 64'(tbl[i].cnt));
      end

      // no-parity instance: FF frame is 40 cycles with stop right after bit 7
      @(negedge clk);
      v1 = 1'b1; d1 = 8'hFF;
      @(posedge clk); #1 v1 = 1'b0; d1 = 8'h00;
      dpos = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         v40[i] = sig1;
         if (done1 && dpos == 0) dpos = i + 1;
      end
      check("np_wave", 64'(v40), 64'h00_FF_FFFF_FFF0);
      check("np_done_pos", 64'(dpos), 64'd40);
      @(negedge clk);
      check("np_cnt", 64'(fc1), 64'd1);
      check("np_idle_sig", 64'({sig1, rdy1}), 64'b11);

      // back-to-back with in_valid held; 8'h33 offered mid-frame must be dropped
      base = ndone;
      k = starts.size();
      send(8'h11, 1'b0);
      in_valid = 1'b1; in_data = 8'h33;
      @(posedge clk); #1 in_data = 8'h22;
      exp_q.push_back(wave(8'h22, 1'b0));
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_done(base + 2);
      check("b2b_starts", 64'(starts.size() - k), 64'd2);
      if (starts.size() >= k + 2) check("b2b_spacing", 64'(starts[k+1] - starts[k]), 64'd45);
      @(negedge clk);
      check("b2b_cnt", 64'(frame_cnt), 64'd8);

      // abort during DATA of the third frame
      do_reset();
      base = ndone;
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      send(8'h56, 1'b0);
      repeat (8) @(negedge clk);
      check("abort_busy", 64'(busy), 64'd1);
      void'(exp_q.pop_back());
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check("abort_sig", 64'(sig), 64'd1);
      check("abort_cnt", 64'(frame_cnt), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_ready", 64'(in_ready), 64'd1);
      repeat (50) @(negedge clk);
      check("abort_no_done", 64'(ndone - base), 64'd2);
      check("abort_idle_sig", 64'(sig), 64'd1);

      // 256 frames wrap the counter
      do_reset();
      base = ndone;
      for (int i = 0; i < 256; i++) begin
         rd = 8'($urandom);
         send(rd, ^rd);
         wait_done(base + i + 1);
         if (i == 254) begin
            @(negedge clk);
            check("cnt_255", 64'(frame_cnt), 64'd255);
         end
      end
      @(negedge clk);
      check("cnt_wrap", 64'(frame_cnt), 64'd0);
      check("done_256", 64'(ndone - base), 64'd256);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/display_tx.md
DISPLAY_TX -- requirements
Module: display_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 = even parity bit sent after the data bits, 0 = no parity bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 8 bits: byte to transmit.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 SHALL have port sig, output, 1 bit: serial line driven into the display; idles high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a frame's stop bit completes.
REQ-011 SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL take a handshake when in_valid and in_ready are both 1 at a rising edge; in_data is latched into an internal shift register on that edge.
REQ-014 SHALL make in_ready = 1 only in IDLE; in_ready SHALL be combinational from the state only, not from in_valid.
REQ-015 SHALL ignore in_valid when in_ready = 0; a byte presented while busy is neither latched nor queued.
REQ-016 SHALL move from IDLE to START on the handshake edge, so sig = 0 from the next cycle.
REQ-017 SHALL hold each bit (start, each data bit, parity, stop) on sig for exactly CLKS_PER_BIT cycles, timed by an internal bit-period counter that reloads at every bit boundary.
REQ-018 SHALL send the data bits LSB first, 8 bits, with a 3-bit index that ends the DATA state after bit 7.
REQ-019 SHALL, when PARITY_EN = 1, send a parity bit equal to the XOR of the 8 latched bits (even parity); when PARITY_EN = 0, the FSM SHALL go from DATA directly to STOP.
REQ-020 SHALL drive sig = 1 during STOP and in IDLE, and register sig (no combinational glitches).
REQ-021 SHALL set the frame length from start to end of stop to (10 + PARITY_EN) x CLKS_PER_BIT cycles.
REQ-022 SHALL, on the last cycle of STOP: assert done = 1 for that one cycle, increment frame_cnt by 1 modulo 256 (255 -> 0 wrap), and have the FSM enter IDLE on the next edge.
REQ-023 SHALL support back-to-back frames with a minimum start-to-start spacing of frame length + 1 cycle, which includes the one IDLE cycle where in_ready = 1.
REQ-024 SHALL make busy = 1 in every state except IDLE, with busy = ~in_ready.
REQ-025 SHALL keep in_data changes after the handshake from affecting the frame in progress.

Reset
REQ-026 SHALL, when reset = 0 at a rising edge, set state = IDLE, sig = 1, done = 0, frame_cnt = 0, and clear the bit counter, bit index and shift register; in_ready is then 1 and busy is 0.
REQ-027 SHALL let reset asserted mid-frame abort the frame: sig returns to 1 on that edge, no done pulse occurs, and frame_cnt is cleared.
REQ-028 SHALL not allow a handshake on an edge where reset = 0, even if in_valid = 1.

Verification
REQ-029 SHALL pass this case (CLKS_PER_BIT = 4, PARITY_EN = 1): send 8'hA5 -> sig = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, parity 0 for 4 cycles, stop 1 for 4 cycles; done pulses once after 44 cycles; frame_cnt = 1.
REQ-030 SHALL pass this case: send 8'h07 -> parity bit = 1 (three ones), frame 44 cycles long.
REQ-031 SHALL pass this case (PARITY_EN = 0): send 8'hFF -> frame is 40 cycles, no parity slot, stop follows bit 7 directly.
REQ-032 SHALL pass this case: in_valid held 1 with 8'h11 then 8'h22 -> both frames transmitted, second start bit exactly 45 cycles after the first; a 8'h33 presented mid-frame for 1 cycle is dropped.
REQ-033 SHALL pass this case: reset = 0 during the DATA state of the 3rd frame -> sig = 1 on the next edge, frame_cnt = 0, no done pulse, in_ready = 1 after reset releases.
REQ-034 SHALL pass this case: 256 complete frames -> frame_cnt wraps to 0, with done pulsing 256 times.
